// File: rtl/pattern_detect_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
// Optional match counter is built only when PATTERN_DETECT_COUNT_EN is defined.
package pattern_detect_pkg;

    // Supported pattern length range.
    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 32;

    // Overlap mode in force after reset unless the instance overrides it.
    localparam logic DEFAULT_OVL_C = 1'b1;

    // Fill level counter, wide enough for the largest supported pattern.
    localparam int FILL_W = $clog2(PAT_LEN_MAX + 1);
    typedef logic [FILL_W-1:0] fill_t;

    // True when a requested pattern length is inside the supported range.
    function automatic logic pat_len_legal(input int n);
        return (n >= PAT_LEN_MIN) && (n <= PAT_LEN_MAX);
    endfunction

endpackage : pattern_detect_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});

    // Count register: reset/clear to zero, otherwise increment and stick at all ones.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/pattern_detect_param.sv
// Parametrised serial bit-pattern detector with run-time pattern, mask and
// overlap mode. The saturating match counter is built only when
// PATTERN_DETECT_COUNT_EN is defined; otherwise match_count is tied to zero.
//
// Stream handshake: in_valid qualifies in_bit on the rising edge of clk. There
// is no back-pressure: every edge with in_valid=1 accepts one bit, except an
// edge that also carries cfg_load, on which the bit is dropped.
module pattern_detect_param
    import pattern_detect_pkg::*;
#(
    parameter int               PAT_LEN      = 6,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT  = 6'b110101,
    parameter logic [PAT_LEN-1:0] DEFAULT_MASK = {PAT_LEN{1'b1}},
    parameter logic             DEFAULT_OVL  = DEFAULT_OVL_C,
    parameter int               CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [PAT_LEN-1:0] cfg_mask,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    // Fill level that means a full window of fresh bits is present.
    localparam fill_t FILL_FULL = fill_t'(PAT_LEN);

    // Active configuration.
    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-1:0] r_mask;
    logic               r_ovl;

    // Shift history (newest bit in the LSB) and saturating fill level.
    logic [PAT_LEN-1:0] r_hist;
    fill_t              r_fill;
    logic               r_match;

    logic               w_accept;
    logic [PAT_LEN-1:0] w_hist_n;
    fill_t              w_fill_n;
    logic [PAT_LEN-1:0] w_diff;
    logic               w_hit;
    logic               w_len_ok;
    logic               w_unused_hist_msb;
    logic               w_unused_len_ok;

    // Parameter sanity flag, kept as a constant net for checkers to bind to.
    assign w_len_ok        = pat_len_legal(PAT_LEN);
    assign w_unused_len_ok = w_len_ok;

    // The oldest history bit falls off the window on every shift.
    assign w_unused_hist_msb = r_hist[PAT_LEN-1];

    // A bit is consumed only when no configuration load shares the edge.
    assign w_accept = in_valid && !cfg_load;

    // Window as it will look after the incoming bit is shifted in.
    assign w_hist_n = {r_hist[PAT_LEN-2:0], in_bit};
    assign w_fill_n = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + fill_t'(1));

    // Masked compare: any differing bit under a set mask bit blocks the hit.
    assign w_diff = (w_hist_n ^ r_pat) & r_mask;
    assign w_hit  = w_accept && (w_fill_n == FILL_FULL) && (w_diff == '0);

    // Configuration register: defaults at reset, replaced wholesale on cfg_load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= DEFAULT_PAT;
            r_mask <= DEFAULT_MASK;
            r_ovl  <= DEFAULT_OVL;
        end else if (cfg_load) begin
            r_pat  <= cfg_pattern;
            r_mask <= cfg_mask;
            r_ovl  <= cfg_overlap;
        end
    end

    // History and fill: cleared by reset/load, shifted on accepted bits, and
    // the fill restarts after a non-overlapping hit so the next window is fresh.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_hist <= w_hist_n;
            if (w_hit && !r_ovl) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_n;
            end
        end
    end

    // Registered one-cycle detection pulse; low on idle and load cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
        end
    end

    assign match = r_match;

`ifdef PATTERN_DETECT_COUNT_EN
    // Saturating hit counter, incremented on the same edge that raises match.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (cnt_clr),
        .i_inc   (w_hit),
        .o_count (match_count)
    );
`else
    logic w_unused_cnt_clr;

    // Counter not built: the count output is constant and the clear is ignored.
    assign w_unused_cnt_clr = cnt_clr;
    assign match_count      = '0;
`endif

endmodule : pattern_detect_param

// File: tb/tb_pattern_detect_param.sv
// Bench for pattern_detect_param: two instances (6-bit default and 4-bit with a
// 2-bit counter) driven in lock-step and compared every cycle with a reference
// model built on a bounded queue of accepted bits.
module tb_pattern_detect_param;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic       cnt_clr;
  logic [5:0] cfg_pat_a;
  logic [5:0] cfg_mask_a;
  logic       cfg_ovl_a;
  logic [3:0] cfg_pat_b;
  logic [3:0] cfg_mask_b;
  logic       cfg_ovl_b;
  logic        match_a;
  logic [15:0] count_a;
  logic        match_b;
  logic [1:0]  count_b;

  int n_assert;
  int n_fail;
  int pulses_a;
  int pulses_b;

  // reference model state
  bit         qa[$];
  bit         qb[$];
  logic [5:0] pa, ma;
  bit         oa;
  logic [3:0] pb, mb;
  bit         ob;
  int         ca, cb;
  bit         exp_ma, exp_mb;

  pattern_detect_param dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pat_a),
    .cfg_mask    (cfg_mask_a),
    .cfg_overlap (cfg_ovl_a),
    .cnt_clr     (cnt_clr),
    .match       (match_a),
    .match_count (count_a)
  );

  pattern_detect_param #(
    .PAT_LEN      (4),
    .DEFAULT_PAT  (4'b1010),
    .DEFAULT_MASK (4'b1111),
    .DEFAULT_OVL  (1'b1),
    .CNT_W        (2)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pat_b),
    .cfg_mask    (cfg_mask_b),
    .cfg_overlap (cfg_ovl_b),
    .cnt_clr     (cnt_clr),
    .match       (match_b),
    .match_count (count_b)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // last n accepted bits (oldest first) against pattern, oldest bit = MSB
  function automatic bit window_hit(input bit q[$], input int n,
                                    input logic [31:0] pat, input logic [31:0] mask);
    if (q.size() < n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mask[n-1-i] && (q[q.size()-n+i] != pat[n-1-i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input bit v, input bit b, input bit ld, input bit clr, input bit r);
    bit hit_a;
    bit hit_b;
    hit_a = 1'b0;
    hit_b = 1'b0;
    if (r) begin
      qa.delete(); qb.delete();
      pa = 6'b110101; ma = 6'b111111; oa = 1'b1;
      pb = 4'b1010;   mb = 4'b1111;   ob = 1'b1;
      ca = 0; cb = 0;
    end else begin
      if (ld) begin
        qa.delete(); qb.delete();
        pa = cfg_pat_a; ma = cfg_mask_a; oa = cfg_ovl_a;
        pb = cfg_pat_b; mb = cfg_mask_b; ob = cfg_ovl_b;
      end else if (v) begin
        qa.push_back(b);
        if (qa.size() > 6) void'(qa.pop_front());
        hit_a = window_hit(qa, 6, {26'b0, pa}, {26'b0, ma});
        if (hit_a && !oa) qa.delete();
        qb.push_back(b);
        if (qb.size() > 4) void'(qb.pop_front());
        hit_b = window_hit(qb, 4, {28'b0, pb}, {28'b0, mb});
        if (hit_b && !ob) qb.delete();
      end
      if (clr) begin
        ca = 0; cb = 0;
      end else begin
        if (hit_a && ca < 65535) ca++;
        if (hit_b && cb < 3) cb++;
      end
    end
    exp_ma = hit_a;
    exp_mb = hit_b;
  endtask

  // one clock: drive, edge, model, sample 1ns after the edge
  task automatic step(input bit v, input bit b, input bit ld, input bit clr, input bit r);
    in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr; rst = r;
    @(posedge clk);
    model_update(v, b, ld, clr, r);
    #1;
    check("match_a", {31'b0, match_a}, {31'b0, exp_ma});
    check("match_b", {31'b0, match_b}, {31'b0, exp_mb});
`ifdef PATTERN_DETECT_COUNT_EN
    check("count_a", {16'b0, count_a}, ca);
    check("count_b", {30'b0, count_b}, cb);
`else
    check("count_a", {16'b0, count_a}, 32'd0);
    check("count_b", {30'b0, count_b}, 32'd0);
`endif
    if (match_a === 1'b1) pulses_a++;
    if (match_b === 1'b1) pulses_b++;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [5:0] p_a, input logic [5:0] m_a, input bit o_a,
                      input logic [3:0] p_b, input logic [3:0] m_b, input bit o_b);
    cfg_pat_a = p_a; cfg_mask_a = m_a; cfg_ovl_a = o_a;
    cfg_pat_b = p_b; cfg_mask_b = m_b; cfg_ovl_b = o_b;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; pulses_a = 0; pulses_b = 0;
    in_valid = 0; in_bit = 0; cfg_load = 0; cnt_clr = 0; rst = 1;
    cfg_pat_a = '0; cfg_mask_a = '0; cfg_ovl_a = 0;
    cfg_pat_b = '0; cfg_mask_b = '0; cfg_ovl_b = 0;

    // reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("reset_match_a", {31'b0, match_a}, 32'd0);
    check("reset_count_a", {16'b0, count_a}, 32'd0);

    // default pattern, overlap: one pulse, right after the 6th bit
    pulses_a = 0;
    feed(32'b110101, 6);
    check("dflt_latency", {31'b0, match_a}, 32'd1);
    feed(32'b01, 2);
    check("dflt_pulses", pulses_a, 32'd1);

    // overlap vs non-overlap on the 4-bit instance
    load(6'b110101, 6'h3f, 1'b1, 4'b1010, 4'b1111, 1'b1);
    pulses_b = 0;
    feed(32'b101010, 6);
    check("ovl_pulses", pulses_b, 32'd2);
    load(6'b110101, 6'h3f, 1'b0, 4'b1010, 4'b1111, 1'b0);
    pulses_b = 0;
    feed(32'b101010, 6);
    check("novl_pulses", pulses_b, 32'd1);

    // mask don't-care
    load(6'b110101, 6'b111011, 1'b1, 4'b1010, 4'b1111, 1'b1);
    pulses_a = 0;
    feed(32'b110001, 6);
    check("mask_pulses", pulses_a, 32'd1);

    // gaps between bits 3 and 4
    load(6'b110101, 6'h3f, 1'b1, 4'b1010, 4'b1111, 1'b1);
    pulses_a = 0;
    feed(32'b110, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    feed(32'b101, 3);
    check("gap_pulses", pulses_a, 32'd1);

    // load with in_valid high drops the bit; fresh pattern needed
    pulses_a = 0;
    feed(32'b11010, 5);
    cfg_pat_a = 6'b110101; cfg_mask_a = 6'h3f; cfg_ovl_a = 1'b1;
    step(1, 1, 1, 0, 0);
    feed(32'b1, 1);
    check("drop_no_hit", pulses_a, 32'd0);
    feed(32'b110101, 6);
    check("reload_pulses", pulses_a, 32'd1);

    // reset mid-stream
    step(0, 0, 0, 0, 1);
    pulses_a = 0;
    feed(32'b11010, 5);
    step(0, 0, 0, 0, 1);
    feed(32'b1, 1);
    check("rst_mid_pulses", pulses_a, 32'd0);
    check("rst_mid_count", {16'b0, count_a}, 32'd0);

    // counter saturation on the 2-bit counter: 5 hits
    load(6'b110101, 6'h3f, 1'b1, 4'b1010, 4'b1111, 1'b1);
    step(0, 0, 0, 1, 0);
    pulses_b = 0;
    feed(32'b101010101010, 12);
    check("sat_pulses", pulses_b, 32'd5);
`ifdef PATTERN_DETECT_COUNT_EN
    check("sat_count", {30'b0, count_b}, 32'd3);
`else
    check("sat_count", {30'b0, count_b}, 32'd0);
`endif
    // clear on the same edge as a hit
    feed(32'b1, 1);
    step(1, 0, 0, 1, 0);
    check("clr_hit_match", {31'b0, match_b}, 32'd1);
    check("clr_hit_count", {30'b0, count_b}, 32'd0);

    // all-zero mask
    load(6'b110101, 6'h3f, 1'b1, 4'b0000, 4'b0000, 1'b0);
    pulses_b = 0;
    feed(32'b10011010, 8);
    check("zmask_novl", pulses_b, 32'd2);
    load(6'b110101, 6'h3f, 1'b1, 4'b0000, 4'b0000, 1'b1);
    pulses_b = 0;
    feed(32'b011001, 6);
    check("zmask_ovl", pulses_b, 32'd3);

    // randomized traffic with occasional loads, clears and resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        load(6'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3f, 1'($urandom),
             4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf, 1'($urandom));
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
             ($urandom_range(0, 59) == 0), ($urandom_range(0, 299) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pattern_detect_param

// File: doc/pattern_detect_param.md
# pattern_detect_param

Parametrised serial bit-pattern detector. It watches a qualified 1-bit stream and raises a registered one-cycle `match` pulse when the most recent `PAT_LEN` accepted bits equal a run-time-loadable pattern. Don't-care bits are selected by a mask, and overlapping or non-overlapping detection is selected at run time. It is the general replacement for the team's fixed-pattern, hard-wired detector FSMs and sits directly after the serial input synchroniser.

## Interface

**Parameters**

- `PAT_LEN`, default 6: pattern length in bits, 2..32.
- `DEFAULT_PAT`, default 6'b110101: pattern in force after reset. The first-received bit is the MSB.
- `DEFAULT_MASK`, default all ones: compare mask in force after reset. 1 = compare, 0 = don't care.
- `DEFAULT_OVL`, default 1: overlap mode after reset.
- `CNT_W`, default 16: match counter width.

**Ports**

- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_bit` is accepted on this edge.
- `in_bit` in 1: serial data.
- `cfg_load` in 1: latch `cfg_pattern`, `cfg_mask` and `cfg_overlap`.
- `cfg_pattern` in `PAT_LEN`: new pattern. MSB is the oldest bit.
- `cfg_mask` in `PAT_LEN`: new compare mask.
- `cfg_overlap` in 1: 1 = overlapping, 0 = non-overlapping.
- `cnt_clr` in 1: clear the match counter.
- `match` out 1: registered one-cycle detection pulse.
- `match_count` out `CNT_W`: saturating match count.

## Operation

**State**

- `pat_q`, `mask_q`, `ovl_q`: active configuration.
- `hist_q[PAT_LEN]`: shift history.
- `fill_q`: 0..`PAT_LEN`, saturating count of bits accepted since the last clear.
- `match`.
- `cnt_q`.

**Reset**

- `pat_q` = `DEFAULT_PAT`, `mask_q` = `DEFAULT_MASK`, `ovl_q` = `DEFAULT_OVL`.
- `hist_q` = 0, `fill_q` = 0, `match` = 0, `match_count` = 0.

**Accepted bit** (`in_valid`=1, `cfg_load`=0)

- History shifts: `hist_n` = {`hist_q[PAT_LEN-2:0]`, `in_bit`}.
- `fill_n` = min(`fill_q`+1, `PAT_LEN`).
- Hit condition: `fill_n`==`PAT_LEN` and ((`hist_n` ^ `pat_q`) & `mask_q`)==0.
- On a hit: `match` is 1 on the next cycle.
- On a hit with `ovl_q`=0: `fill_q` returns to 0, so the next `PAT_LEN` bits must all arrive fresh.
- On a hit with `ovl_q`=1: `fill_q` stays at `PAT_LEN`, and overlapping occurrences each pulse.

**Idle cycle** (`in_valid`=0)

- History and fill hold.
- `match` returns to 0.

**Config load** (`cfg_load`=1)

- Latches the new pattern, mask and overlap mode.
- Clears `hist_q` and `fill_q`.
- `match` goes to 0.
- `in_valid` in the same cycle is ignored; the bit is dropped.
- The counter is unaffected.

**Edge cases**

- An all-zero mask matches on every accepted bit once `fill_q` is full, in either mode: every `PAT_LEN`-th bit when `ovl_q`=0, every bit when `ovl_q`=1.
- No match can occur before `PAT_LEN` bits have been accepted since reset, load or a non-overlap hit.

## Timing

- Detection latency: `match` asserts in the cycle after the edge that accepts the completing bit.
- `match` is never high for two consecutive cycles unless there are two consecutive accepted hits.
- `cfg_load` takes effect for the bit accepted on the following edge.
- `rst` has priority over `cfg_load`, `cnt_clr` and `in_valid`. Reset mid-stream discards the partial history.
- `match_count` increments on the same edge that sets `match`, and saturates at all ones.
- When `cnt_clr` and a hit occur on the same edge, the clear wins and the count goes to 0.

## Configuration

- Macro: `PATTERN_DETECT_COUNT_EN`.
- Defined: the `CNT_W` saturating counter is built, with `cnt_clr` honoured as described.
- Undefined: no counter flops are built, `match_count` is tied to 0, and `cnt_clr` is ignored. `match` behaviour is identical in both builds.

## Structure

- Package `pattern_detect_pkg` holds:
  - the `PAT_LEN` limit constants (min 2, max 32);
  - the default overlap constant;
  - a `fill_t` typedef sized `$clog2(PAT_LEN_MAX+1)`.
- Sub-module `sat_counter`, parametrised on `CNT_W`, with inputs clear and increment. It is instantiated only under `PATTERN_DETECT_COUNT_EN`.

## Test plan

- **Default pattern, overlap:** reset, then feed 1,1,0,1,0,1,0,1 with `in_valid`=1 throughout → `match` pulses exactly once, in the cycle after the 6th bit; `match_count`=1.
- **Overlap vs non-overlap:** load pattern 4'b1010, mask 4'b1111, PAT_LEN=4 build, feed 1,0,1,0,1,0 → `ovl`=1 gives 2 pulses (after bits 4 and 6); `ovl`=0 gives 1 pulse (after bit 4).
- **Mask don't-care:** pattern 6'b110101, mask 6'b111011, feed 1,1,0,0,0,1 → `match` pulses once.
- **Gaps and reload:**
  - Feed the default pattern with `in_valid` low for 3 cycles between bits 3 and 4 → `match` still pulses once.
  - Assert `cfg_load` with `in_valid`=1 → that bit is dropped; a full new pattern is needed before the next hit.
- **Reset mid-stream:** after 5 correct bits, pulse `rst`, then feed the 6th bit → no `match`; `match_count`=0.
- **Counter:** with CNT_W=2, force 5 hits → `match_count` sticks at 3. `cnt_clr` on the same edge as a hit → count 0. With the macro undefined, the count stays at 0.
